// File: rtl/reg_scoreboard_pkg.sv
// Shared RiSC-16 register-file constants and the per-register pending-counter width
// used by the issue scoreboard.
package reg_scoreboard_pkg;
   localparam int p_REG_ADDR_LEN  = 3;
   localparam int p_REG_FILE_SIZE = 8;
   localparam int p_WORD_LEN      = 16;
   localparam int p_CNT_WIDTH     = 2;

   localparam logic [p_REG_ADDR_LEN-1:0] c_R0      = {p_REG_ADDR_LEN{1'b0}};
   localparam logic [p_CNT_WIDTH-1:0]    c_CNT_MAX = {p_CNT_WIDTH{1'b1}};

   // r0 is hardwired to zero, so it never carries a pending write.
   function automatic logic is_tracked(input logic [p_REG_ADDR_LEN-1:0] addr);
      return addr != c_R0;
   endfunction
endpackage

// File: rtl/reg_scoreboard_counter.sv
// Pending-write counter for one architectural register. Decrements beyond
// cnt+inc clamp to zero and raise a one-cycle underflow pulse.
module reg_scoreboard_counter
   import reg_scoreboard_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inc,
   input  logic                   dec_r,
   input  logic                   dec_c,
   output logic [p_CNT_WIDTH-1:0] cnt,
   output logic                   nonzero,
   output logic                   at_max,
   output logic                   underflow
);
   logic [p_CNT_WIDTH-1:0] cnt_r;
   logic [p_CNT_WIDTH-1:0] next_s;
   logic [p_CNT_WIDTH:0]   up_s;
   logic [p_CNT_WIDTH:0]   dn_s;
   logic [p_CNT_WIDTH:0]   diff_s;

   assign up_s      = {1'b0, cnt_r} + {{p_CNT_WIDTH{1'b0}}, inc};
   assign dn_s      = {{p_CNT_WIDTH{1'b0}}, dec_r} + {{p_CNT_WIDTH{1'b0}}, dec_c};
   assign diff_s    = up_s - dn_s;
   assign underflow = dn_s > up_s;

   // Next-count selection: clamp to zero on underflow, to max if ever above range.
   always_comb begin
      next_s = diff_s[p_CNT_WIDTH-1:0];
      if (underflow) begin
         next_s = {p_CNT_WIDTH{1'b0}};
      end else if (diff_s[p_CNT_WIDTH]) begin
         next_s = c_CNT_MAX;
      end else begin
         next_s = diff_s[p_CNT_WIDTH-1:0];
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {p_CNT_WIDTH{1'b0}};
      end else begin
         cnt_r <= next_s;
      end
   end

   assign cnt     = cnt_r;
   assign nonzero = cnt_r != {p_CNT_WIDTH{1'b0}};
   assign at_max  = cnt_r == c_CNT_MAX;
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the RiSC-16 register file: tracks in-flight writes
// per register and withholds issue on RAW hazards or counter saturation.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_issue_valid,
   input  logic [p_REG_ADDR_LEN-1:0]  i_issue_src1,
   input  logic                       i_issue_src1_used,
   input  logic [p_REG_ADDR_LEN-1:0]  i_issue_src2,
   input  logic                       i_issue_src2_used,
   input  logic                       i_issue_wr_en,
   input  logic [p_REG_ADDR_LEN-1:0]  i_issue_tgt,
   output logic                       o_issue_ready,
   input  logic                       i_retire_valid,
   input  logic [p_REG_ADDR_LEN-1:0]  i_retire_tgt,
   input  logic                       i_cancel_valid,
   input  logic [p_REG_ADDR_LEN-1:0]  i_cancel_tgt,
   output logic [p_REG_FILE_SIZE-1:0] o_busy,
   output logic                       o_idle,
   output logic                       o_err
);
   logic [p_CNT_WIDTH-1:0]     cnt_s [p_REG_FILE_SIZE];
   logic [p_REG_FILE_SIZE-1:0] nonzero_s;
   logic [p_REG_FILE_SIZE-1:0] at_max_s;
   logic [p_REG_FILE_SIZE-1:0] underflow_s;
   logic [p_REG_FILE_SIZE-1:1] inc_s;
   logic [p_REG_FILE_SIZE-1:1] dec_r_s;
   logic [p_REG_FILE_SIZE-1:1] dec_c_s;
   logic                       hazard_s;
   logic                       sat_s;
   logic                       accept_s;
   logic                       err_r;

   assign cnt_s[0]       = {p_CNT_WIDTH{1'b0}};
   assign nonzero_s[0]   = 1'b0;
   assign at_max_s[0]    = 1'b0;
   assign underflow_s[0] = 1'b0;

   assign accept_s = i_issue_valid && o_issue_ready;

   // Address decode of issue/retire/cancel into per-register strobes.
   always_comb begin
      inc_s   = {(p_REG_FILE_SIZE-1){1'b0}};
      dec_r_s = {(p_REG_FILE_SIZE-1){1'b0}};
      dec_c_s = {(p_REG_FILE_SIZE-1){1'b0}};
      for (int k = 1; k < p_REG_FILE_SIZE; k++) begin
         inc_s[k]   = accept_s && i_issue_wr_en && (i_issue_tgt == p_REG_ADDR_LEN'(k));
         dec_r_s[k] = i_retire_valid && (i_retire_tgt == p_REG_ADDR_LEN'(k));
         dec_c_s[k] = i_cancel_valid && (i_cancel_tgt == p_REG_ADDR_LEN'(k));
      end
   end

   for (genvar k = 1; k < p_REG_FILE_SIZE; k++) begin : g_cnt
      reg_scoreboard_counter u_cnt (
         .clk       (i_clk),
         .rst_n     (i_rst_n),
         .inc       (inc_s[k]),
         .dec_r     (dec_r_s[k]),
         .dec_c     (dec_c_s[k]),
         .cnt       (cnt_s[k]),
         .nonzero   (nonzero_s[k]),
         .at_max    (at_max_s[k]),
         .underflow (underflow_s[k])
      );
   end

   // Ready looks only at registered counts; a same-cycle retire is not bypassed
   // because the register file commits on that same edge.
   always_comb begin
      hazard_s = 1'b0;
      if (i_issue_src1_used && is_tracked(i_issue_src1) &&
          (cnt_s[i_issue_src1] != {p_CNT_WIDTH{1'b0}})) begin
         hazard_s = 1'b1;
      end else if (i_issue_src2_used && is_tracked(i_issue_src2) &&
                   (cnt_s[i_issue_src2] != {p_CNT_WIDTH{1'b0}})) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
      sat_s = i_issue_wr_en && is_tracked(i_issue_tgt) && at_max_s[i_issue_tgt];
   end

   assign o_issue_ready = !hazard_s && !sat_s;

   // Sticky protocol-error flag, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | (|underflow_s);
      end
   end

   assign o_err  = err_r;
   assign o_busy = nonzero_s;
   assign o_idle = ~|nonzero_s;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: reset, RAW stall, simultaneous
// issue/retire, saturation, r0/cancel handling and sticky underflow error.
module tb_reg_scoreboard;
   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_issue_valid;
   logic [2:0] i_issue_src1;
   logic       i_issue_src1_used;
   logic [2:0] i_issue_src2;
   logic       i_issue_src2_used;
   logic       i_issue_wr_en;
   logic [2:0] i_issue_tgt;
   logic       o_issue_ready;
   logic       i_retire_valid;
   logic [2:0] i_retire_tgt;
   logic       i_cancel_valid;
   logic [2:0] i_cancel_tgt;
   logic [7:0] o_busy;
   logic       o_idle;
   logic       o_err;

   int n_checks = 0;
   int n_fail   = 0;

   reg_scoreboard dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_issue_valid     (i_issue_valid),
      .i_issue_src1      (i_issue_src1),
      .i_issue_src1_used (i_issue_src1_used),
      .i_issue_src2      (i_issue_src2),
      .i_issue_src2_used (i_issue_src2_used),
      .i_issue_wr_en     (i_issue_wr_en),
      .i_issue_tgt       (i_issue_tgt),
      .o_issue_ready     (o_issue_ready),
      .i_retire_valid    (i_retire_valid),
      .i_retire_tgt      (i_retire_tgt),
      .i_cancel_valid    (i_cancel_valid),
      .i_cancel_tgt      (i_cancel_tgt),
      .o_busy            (o_busy),
      .o_idle            (o_idle),
      .o_err             (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic idle_inputs();
      i_issue_valid = 1'b0; i_issue_src1 = 3'd0; i_issue_src1_used = 1'b0;
      i_issue_src2 = 3'd0; i_issue_src2_used = 1'b0; i_issue_wr_en = 1'b0;
      i_issue_tgt = 3'd0; i_retire_valid = 1'b0; i_retire_tgt = 3'd0;
      i_cancel_valid = 1'b0; i_cancel_tgt = 3'd0;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic issue_wr(input logic [2:0] tgt);
      idle_inputs();
      i_issue_valid = 1'b1; i_issue_wr_en = 1'b1; i_issue_tgt = tgt;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      issue_wr(3'd3);
      i_retire_valid = 1'b1; i_retire_tgt = 3'd4;
      repeat (3) tick();
      n_checks++;
      if (o_busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy got %h want 00", o_busy); end
      n_checks++;
      if (o_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", o_idle); end
      n_checks++;
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", o_err); end
      i_issue_src1 = 3'd3; i_issue_src1_used = 1'b1; i_issue_src2 = 3'd5; i_issue_src2_used = 1'b1;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_issue_ready); end
      idle_inputs();
      i_rst_n = 1'b1;
      tick();
      n_checks++;
      if (o_busy !== 8'h00 || o_idle !== 1'b1) begin
         n_fail++; $display("FAIL post_reset got busy=%h idle=%b want 00/1", o_busy, o_idle);
      end
   endtask

   task automatic test_raw_stall();
      issue_wr(3'd3);
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got %b want 1", o_issue_ready); end
      tick();
      idle_inputs();
      i_issue_valid = 1'b1; i_issue_src1 = 3'd3; i_issue_src1_used = 1'b1;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %b want 0", o_issue_ready); end
      n_checks++;
      if (o_busy !== 8'h08 || o_idle !== 1'b0) begin
         n_fail++; $display("FAIL raw_busy got busy=%h idle=%b want 08/0", o_busy, o_idle);
      end
      i_retire_valid = 1'b1; i_retire_tgt = 3'd3;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got %b want 0", o_issue_ready); end
      tick();
      i_retire_valid = 1'b0;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b want 1", o_issue_ready); end
      n_checks++;
      if (o_busy !== 8'h00 || o_idle !== 1'b1) begin
         n_fail++; $display("FAIL raw_clear got busy=%h idle=%b want 00/1", o_busy, o_idle);
      end
      // src2 path: r3 pending again, read through src2 only.
      issue_wr(3'd3);
      tick();
      idle_inputs();
      i_issue_src2 = 3'd3; i_issue_src2_used = 1'b1;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_src2 got %b want 0", o_issue_ready); end
      i_issue_src2_used = 1'b0;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_src2_unused got %b want 1", o_issue_ready); end
      i_retire_valid = 1'b1; i_retire_tgt = 3'd3;
      tick();
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      issue_wr(3'd5);
      tick();
      n_checks++;
      if (o_busy !== 8'h20) begin n_fail++; $display("FAIL simul_setup got %h want 20", o_busy); end
      issue_wr(3'd5);
      i_retire_valid = 1'b1; i_retire_tgt = 3'd5;
      tick();
      idle_inputs();
      n_checks++;
      if (o_busy !== 8'h20) begin n_fail++; $display("FAIL simul_hold got %h want 20", o_busy); end
      i_retire_valid = 1'b1; i_retire_tgt = 3'd5;
      tick();
      idle_inputs();
      n_checks++;
      if (o_busy !== 8'h00 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL simul_count got busy=%h err=%b want 00/0", o_busy, o_err);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         issue_wr(3'd2);
         #1;
         n_checks++;
         if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_fill%0d got %b want 1", i, o_issue_ready); end
         tick();
      end
      issue_wr(3'd2);
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_block got %b want 0", o_issue_ready); end
      tick();
      idle_inputs();
      i_issue_valid = 1'b1; i_issue_src1 = 3'd4; i_issue_src1_used = 1'b1;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_src_only got %b want 1", o_issue_ready); end
      issue_wr(3'd1);
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_other_tgt got %b want 1", o_issue_ready); end
      idle_inputs();
      // Blocked 4th issue must not have counted: three retires drain r2 without error.
      for (int i = 0; i < 3; i++) begin
         i_retire_valid = 1'b1; i_retire_tgt = 3'd2;
         tick();
         n_checks++;
         if (o_busy[2] !== (i < 2)) begin n_fail++; $display("FAIL sat_drain%0d got %b want %b", i, o_busy[2], i < 2); end
      end
      idle_inputs();
      n_checks++;
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL sat_err got %b want 0", o_err); end
   endtask

   task automatic test_r0_cancel();
      issue_wr(3'd0);
      i_issue_src1 = 3'd0; i_issue_src1_used = 1'b1;
      #1;
      n_checks++;
      if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready got %b want 1", o_issue_ready); end
      tick();
      n_checks++;
      if (o_busy !== 8'h00 || o_idle !== 1'b1) begin
         n_fail++; $display("FAIL r0_busy got busy=%h idle=%b want 00/1", o_busy, o_idle);
      end
      idle_inputs();
      i_retire_valid = 1'b1; i_retire_tgt = 3'd0;
      i_cancel_valid = 1'b1; i_cancel_tgt = 3'd0;
      tick();
      n_checks++;
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL r0_dec_err got %b want 0", o_err); end
      issue_wr(3'd6);
      tick();
      issue_wr(3'd6);
      tick();
      idle_inputs();
      n_checks++;
      if (o_busy !== 8'h40) begin n_fail++; $display("FAIL cancel_setup got %h want 40", o_busy); end
      i_retire_valid = 1'b1; i_retire_tgt = 3'd6;
      i_cancel_valid = 1'b1; i_cancel_tgt = 3'd6;
      tick();
      idle_inputs();
      n_checks++;
      if (o_busy !== 8'h00 || o_err !== 1'b0 || o_idle !== 1'b1) begin
         n_fail++; $display("FAIL cancel_net2 got busy=%h err=%b idle=%b want 00/0/1", o_busy, o_err, o_idle);
      end
   endtask

   task automatic test_underflow();
      issue_wr(3'd1);
      tick();
      idle_inputs();
      i_retire_valid = 1'b1; i_retire_tgt = 3'd7;
      tick();
      idle_inputs();
      n_checks++;
      if (o_err !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b want 1", o_err); end
      n_checks++;
      if (o_busy !== 8'h02) begin n_fail++; $display("FAIL uf_busy got %h want 02", o_busy); end
      repeat (4) tick();
      n_checks++;
      if (o_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", o_err); end
      // Assert reset between edges: state must clear without a clock edge.
      #2;
      i_rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_err !== 1'b0 || o_busy !== 8'h00 || o_idle !== 1'b1) begin
         n_fail++; $display("FAIL async_reset got err=%b busy=%h idle=%b want 0/00/1", o_err, o_busy, o_idle);
      end
      tick();
      i_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      i_rst_n = 1'b0;
      test_reset();
      test_raw_stall();
      test_simultaneous();
      test_saturation();
      test_r0_cancel();
      test_underflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
